// File: rtl/hazard_pkg.sv
// Shared types and defaults for the 6-stage pipeline hazard/control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M1 = 2'b10,
        FWD_M2 = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int LU_BUBBLES_DEFAULT = 2;

endpackage

// File: rtl/hazard_ctrl6_fwd_sel_unit.sv
// One Execute-stage operand's forwarding select; the youngest producing stage wins.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m1,
    input  logic [REG_AW-1:0] rd_m2,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m1,
    input  logic              reg_write_m2,
    input  logic              reg_write_w,
    input  logic              load_m1,
    input  logic              load_m2,
    output fwd_sel_t          sel
);

    // Loads in M1/M2 have no data yet, so only ALU results are taken from those stages.
    always_comb begin
        sel = FWD_RF;
        if (rs != '0) begin
            if (reg_write_m1 && !load_m1 && rd_m1 == rs)
                sel = FWD_M1;
            else if (reg_write_m2 && !load_m2 && rd_m2 == rs)
                sel = FWD_M2;
            else if (reg_write_w && rd_w == rs)
                sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl6.sv
// Hazard/control unit for the F-D-E-M1-M2-W pipeline: stalls, flushes and forwarding selects.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl6
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LU_BUBBLES = LU_BUBBLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m1,
    input  logic [REG_AW-1:0] rd_m2,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m1,
    input  logic              reg_write_m2,
    input  logic              reg_write_w,
    input  logic              load_e,
    input  logic              load_m1,
    input  logic              load_m2,
    input  logic              mem_access_m2,
    input  logic              dmem_ready,
    input  logic              pc_src_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m1,
    output logic              stall_m2,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_lu_cycles,
    output logic [31:0]       perf_mem_cycles
`endif
);

    localparam int CNT_W = (LU_BUBBLES > 2) ? $clog2(LU_BUBBLES) : 1;
    localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LU_BUBBLES - 1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic             mem_stall, lu_e, lu_m1, lu_stall;
    fwd_sel_t         fwd_a, fwd_b;

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs(rs1_e), .rd_m1(rd_m1), .rd_m2(rd_m2), .rd_w(rd_w),
        .reg_write_m1(reg_write_m1), .reg_write_m2(reg_write_m2), .reg_write_w(reg_write_w),
        .load_m1(load_m1), .load_m2(load_m2), .sel(fwd_a)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs(rs2_e), .rd_m1(rd_m1), .rd_m2(rd_m2), .rd_w(rd_w),
        .reg_write_m1(reg_write_m1), .reg_write_m2(reg_write_m2), .reg_write_w(reg_write_w),
        .load_m1(load_m1), .load_m2(load_m2), .sel(fwd_b)
    );

    assign mem_stall = mem_access_m2 && !dmem_ready;
    assign lu_e  = load_e  && rd_e  != '0 && (rd_e  == rs1_d || rd_e  == rs2_d);
    assign lu_m1 = load_m1 && rd_m1 != '0 && (rd_m1 == rs1_d || rd_m1 == rs2_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        lu_stall    = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m1    = 1'b0;
        stall_m2    = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        forward_a_e = fwd_a;
        forward_b_e = fwd_b;

        case (state_q)
            RUN:      if (mem_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase

        // Memory wait freezes the whole pipe; branch and load-use are re-judged once it clears.
        if (mem_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m1 = 1'b1;
            stall_m2 = 1'b1;
            flush_w  = 1'b1;
        end else if (pc_src_e) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            lu_cnt_d = '0;
        end else if (lu_cnt_q != '0) begin
            lu_stall = 1'b1;
            lu_cnt_d = lu_cnt_q - 1'b1;
        end else if (lu_e) begin
            lu_stall = 1'b1;
            lu_cnt_d = LU_LOAD;
        end else if (lu_m1) begin
            lu_stall = 1'b1;
        end

        if (lu_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end

        if (reset) begin
            stall_f     = 1'b0;
            stall_d     = 1'b0;
            stall_e     = 1'b0;
            stall_m1    = 1'b0;
            stall_m2    = 1'b0;
            flush_d     = 1'b0;
            flush_e     = 1'b0;
            flush_w     = 1'b0;
            forward_a_e = FWD_RF;
            forward_b_e = FWD_RF;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lu_cycles  <= '0;
            perf_mem_cycles <= '0;
        end else begin
            if (lu_stall && perf_lu_cycles != '1)
                perf_lu_cycles <= perf_lu_cycles + 32'd1;
            if (mem_stall && perf_mem_cycles != '1)
                perf_mem_cycles <= perf_mem_cycles + 32'd1;
        end
    end
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl6.sv
// Self-checking bench for hazard_ctrl6: rule-level reference model plus directed literal checks.
module tb_hazard_ctrl6;
    localparam int AW = 5;
    localparam int LU = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m1, rd_m2, rd_w;
    logic reg_write_m1, reg_write_m2, reg_write_w, load_e, load_m1, load_m2;
    logic mem_access_m2, dmem_ready, pc_src_e;
    logic stall_f, stall_d, stall_e, stall_m1, stall_m2, flush_d, flush_e, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cycles, perf_mem_cycles;
`endif

    int n_chk = 0;
    int n_pass = 0;

    hazard_ctrl6 #(.REG_AW(AW), .LU_BUBBLES(LU)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m1(rd_m1), .rd_m2(rd_m2), .rd_w(rd_w),
        .reg_write_m1(reg_write_m1), .reg_write_m2(reg_write_m2), .reg_write_w(reg_write_w),
        .load_e(load_e), .load_m1(load_m1), .load_m2(load_m2),
        .mem_access_m2(mem_access_m2), .dmem_ready(dmem_ready), .pc_src_e(pc_src_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m1(stall_m1),
        .stall_m2(stall_m2), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
`ifdef HAZARD_PERF_EN
        , .perf_lu_cycles(perf_lu_cycles), .perf_mem_cycles(perf_mem_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [4:0] stalls();
        return {stall_f, stall_d, stall_e, stall_m1, stall_m2};
    endfunction

    function automatic logic [2:0] flushes();
        return {flush_d, flush_e, flush_w};
    endfunction

    // Youngest-first scan over the producing stages (M1, M2, W).
    function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
        logic [AW-1:0] rd[3];
        logic ok[3];
        logic [1:0] code[3];
        rd[0] = rd_m1; ok[0] = reg_write_m1 && !load_m1; code[0] = 2'b10;
        rd[1] = rd_m2; ok[1] = reg_write_m2 && !load_m2; code[1] = 2'b11;
        rd[2] = rd_w;  ok[2] = reg_write_w;              code[2] = 2'b01;
        if (rs == 0) return 2'b00;
        for (int i = 0; i < 3; i++)
            if (ok[i] && rd[i] == rs) return code[i];
        return 2'b00;
    endfunction

    // Reference model state: bubbles still owed to a consumer after a load in E.
    int bubbles_left = 0;
    longint m_perf_lu = 0, m_perf_mem = 0;

    always @(negedge clk) begin
        bit mem, lu_from_e, lu_from_m1, bubble;
        logic [4:0] e_st;
        logic [2:0] e_fl;
        logic [1:0] e_fa, e_fb;
        mem = mem_access_m2 && !dmem_ready;
        lu_from_e  = load_e  && rd_e  != 0 && (rd_e  == rs1_d || rd_e  == rs2_d);
        lu_from_m1 = load_m1 && rd_m1 != 0 && (rd_m1 == rs1_d || rd_m1 == rs2_d);
        bubble = 0;
        e_st = '0; e_fl = '0;
        e_fa = model_fwd(rs1_e);
        e_fb = model_fwd(rs2_e);
        if (reset) begin
            e_fa = 0; e_fb = 0;
            bubbles_left = 0;
            m_perf_lu = 0; m_perf_mem = 0;
        end else if (mem) begin
            e_st = 5'b11111; e_fl = 3'b001;
        end else if (pc_src_e) begin
            e_fl = 3'b110;
            bubbles_left = 0;
        end else if (bubbles_left > 0 || lu_from_e || lu_from_m1) begin
            bubble = 1;
            e_st = 5'b11000; e_fl = 3'b010;
        end
        chk("stall", {27'd0, stalls()}, {27'd0, e_st});
        chk("flush", {29'd0, flushes()}, {29'd0, e_fl});
        chk("fwd_a", {30'd0, forward_a_e}, {30'd0, e_fa});
        chk("fwd_b", {30'd0, forward_b_e}, {30'd0, e_fb});
`ifdef HAZARD_PERF_EN
        chk("perf_lu", perf_lu_cycles, 32'(m_perf_lu));
        chk("perf_mem", perf_mem_cycles, 32'(m_perf_mem));
`endif
        if (!reset) begin
            if (bubble) begin
                if (bubbles_left > 0) bubbles_left--;
                else if (lu_from_e) bubbles_left = LU - 1;
                if (m_perf_lu < 64'hFFFF_FFFF) m_perf_lu++;
            end
            if (mem && m_perf_mem < 64'hFFFF_FFFF) m_perf_mem++;
        end
    end

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m1 = 0; rd_m2 = 0; rd_w = 0;
        reg_write_m1 = 0; reg_write_m2 = 0; reg_write_w = 0;
        load_e = 0; load_m1 = 0; load_m2 = 0;
        mem_access_m2 = 0; dmem_ready = 0; pc_src_e = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        // Reset with active-looking inputs: everything must read zero.
        mem_access_m2 = 1; pc_src_e = 1; rs1_e = 5; rd_m1 = 5; reg_write_m1 = 1;
        #3;
        chk("reset_stall", {27'd0, stalls()}, 32'd0);
        chk("reset_flush", {29'd0, flushes()}, 32'd0);
        chk("reset_fwd_a", {30'd0, forward_a_e}, 32'd0);
        tick(); tick();
        reset = 0; clear_inputs();

        // Forwarding priority
        tick(); rs1_e = 5; rd_m1 = 5; reg_write_m1 = 1; rd_w = 5; reg_write_w = 1;
        #2 chk("fwd_m1_over_w", {30'd0, forward_a_e}, 32'd2);
        tick(); reg_write_m1 = 0;
        #2 chk("fwd_w", {30'd0, forward_a_e}, 32'd1);
        tick(); rs1_e = 0;
        #2 chk("fwd_x0", {30'd0, forward_a_e}, 32'd0);

        // Load in E feeding D: two bubbles, then forward from W
        tick(); clear_inputs(); load_e = 1; rd_e = 6; rs2_d = 6;
        #2 chk("lu_e_bubble1", {27'd0, stalls()}, 32'b11000);
        tick(); load_e = 0; load_m1 = 1; rd_m1 = 6; reg_write_m1 = 1;
        #2 chk("lu_e_bubble2", {27'd0, stalls()}, 32'b11000);
        tick(); load_m1 = 0; reg_write_m1 = 0; load_m2 = 1; rd_m2 = 6; reg_write_m2 = 1;
        #2 chk("lu_e_release", {27'd0, stalls()}, 32'd0);
        tick(); load_m2 = 0; reg_write_m2 = 0; rd_w = 6; reg_write_w = 1; rs2_e = 6; rs2_d = 0;
        #2 chk("lu_fwd_b_w", {30'd0, forward_b_e}, 32'd1);

        // Load in M1 feeding D: single bubble; load to x0: none
        tick(); clear_inputs(); load_m1 = 1; rd_m1 = 7; rs1_d = 7;
        #2 chk("lu_m1_bubble", {29'd0, flushes()}, 32'b010);
        tick(); load_m1 = 0; load_m2 = 1; rd_m2 = 7;
        #2 chk("lu_m1_one_only", {27'd0, stalls()}, 32'd0);
        tick(); clear_inputs(); load_e = 1; rd_e = 0;
        #2 chk("lu_x0", {27'd0, stalls()}, 32'd0);

        // Memory wait for three cycles with a pending branch
        tick(); clear_inputs(); mem_access_m2 = 1; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #2;
            chk("mem_stall", {27'd0, stalls()}, 32'b11111);
            chk("mem_flush", {29'd0, flushes()}, 32'b001);
        end
        tick(); dmem_ready = 1;
        #2 chk("mem_release_stall", {27'd0, stalls()}, 32'd0);
        chk("mem_release_branch", {29'd0, flushes()}, 32'b110);

        // Branch while a load-use bubble is owed
        tick(); clear_inputs(); load_e = 1; rd_e = 6; rs2_d = 6;
        #2 chk("br_lu_start", {27'd0, stalls()}, 32'b11000);
        tick(); load_e = 0; load_m1 = 1; rd_m1 = 6; pc_src_e = 1;
        #2 chk("br_lu_flush", {29'd0, flushes()}, 32'b110);
        chk("br_lu_nostall", {27'd0, stalls()}, 32'd0);
        tick(); clear_inputs();
        #2 chk("br_lu_cleared", {27'd0, stalls()}, 32'd0);

        // Reset in the middle of a memory wait
        tick(); clear_inputs(); mem_access_m2 = 1; rs1_e = 5; rd_m1 = 5; reg_write_m1 = 1;
        #1 chk("pre_rst_mem", {27'd0, stalls()}, 32'b11111);
        #1 reset = 1;
        #1 chk("mid_rst_stall", {27'd0, stalls()}, 32'd0);
        chk("mid_rst_fwd", {30'd0, forward_a_e}, 32'd0);
        tick(); reset = 0; clear_inputs();
        #2 chk("post_rst_run", {27'd0, stalls()}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk("post_rst_perf_mem", perf_mem_cycles, 32'd0);
`endif

        // Reset while a load-use bubble is owed clears the counter
        tick(); load_e = 1; rd_e = 6; rs2_d = 6;
        tick(); clear_inputs(); reset = 1;
        tick(); reset = 0;
        #2 chk("rst_clears_lu", {27'd0, stalls()}, 32'd0);

        // Randomised phase, small register range so matches are frequent
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset         = ($urandom_range(0, 63) == 0);
            rs1_d         = AW'($urandom_range(0, 3));
            rs2_d         = AW'($urandom_range(0, 3));
            rs1_e         = AW'($urandom_range(0, 3));
            rs2_e         = AW'($urandom_range(0, 3));
            rd_e          = AW'($urandom_range(0, 3));
            rd_m1         = AW'($urandom_range(0, 3));
            rd_m2         = AW'($urandom_range(0, 3));
            rd_w          = AW'($urandom_range(0, 3));
            reg_write_m1  = $urandom_range(0, 1) == 1;
            reg_write_m2  = $urandom_range(0, 1) == 1;
            reg_write_w   = $urandom_range(0, 1) == 1;
            load_e        = $urandom_range(0, 3) == 0;
            load_m1       = $urandom_range(0, 3) == 0;
            load_m2       = $urandom_range(0, 3) == 0;
            mem_access_m2 = $urandom_range(0, 2) == 0;
            dmem_ready    = $urandom_range(0, 1) == 1;
            pc_src_e      = $urandom_range(0, 9) == 0;
        end
        tick(); clear_inputs();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
